// File: rtl/io_bridge.sv
// Peripheral bridge: interval timer, LED register and switch/irq synchronizers on the CPU bus.
// Reads are combinational (zero latency), writes land on the strobe edge; no backpressure.
module io_bridge #(
  parameter logic [31:0] TIMER_BASE = 32'h0000_7F00,
  parameter logic [31:0] LED_ADDR   = 32'h0000_7F10,
  parameter logic [31:0] SW_ADDR    = 32'h0000_7F14
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [29:0] PrAddr,
  input  logic [31:0] PrWD,
  input  logic [3:0]  PrBE,
  input  logic        IOWrite,
  output logic [31:0] PrRD,
  output logic [5:0]  HWInt,
  input  logic [31:0] sw_in,
  output logic [31:0] led_out,
  input  logic        ext_irq
);

  localparam logic [31:0] PRESET_BYTE = TIMER_BASE + 32'd4;
  localparam logic [31:0] COUNT_BYTE  = TIMER_BASE + 32'd8;
  localparam logic [29:0] A_CTRL   = TIMER_BASE[31:2];
  localparam logic [29:0] A_PRESET = PRESET_BYTE[31:2];
  localparam logic [29:0] A_COUNT  = COUNT_BYTE[31:2];
  localparam logic [29:0] A_LED    = LED_ADDR[31:2];
  localparam logic [29:0] A_SW     = SW_ADDR[31:2];

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CNT, S_INT} state_t;

  state_t      state, state_nxt;
  logic [3:0]  ctrl;
  logic [31:0] preset, count, count_nxt, led;
  logic [31:0] sw_s1, sw_s2;
  logic        ext_s1, ext_s2;
  logic        irq_pending, irq_set, en_clr;
  logic        wr_ctrl, wr_preset, wr_led;

  wire       en     = ctrl[0];
  wire [1:0] mode   = ctrl[2:1];
  wire       im     = ctrl[3];
  wire       reload = (mode == 2'b01);

  assign wr_ctrl   = IOWrite && (PrAddr == A_CTRL);
  assign wr_preset = IOWrite && (PrAddr == A_PRESET);
  assign wr_led    = IOWrite && (PrAddr == A_LED);

  function automatic logic [31:0] merge_bytes(input logic [31:0] old,
                                              input logic [31:0] wd,
                                              input logic [3:0]  be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++)
      if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
    return r;
  endfunction

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    irq_set   = 1'b0;
    en_clr    = 1'b0;
    case (state)
      S_IDLE: if (en) state_nxt = S_LOAD;
      S_LOAD: begin
        count_nxt = preset;
        state_nxt = S_CNT;
      end
      S_CNT: begin
        if (!en) begin
          state_nxt = S_IDLE;
        end else if (count <= 32'd1) begin
          count_nxt = '0;
          state_nxt = S_INT;
        end else begin
          count_nxt = count - 32'd1;
        end
      end
      S_INT: begin
        if (reload) begin
          state_nxt = S_LOAD;
        end else begin
          irq_set   = 1'b1;
          en_clr    = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      ctrl        <= '0;
      preset      <= '0;
      count       <= '0;
      led         <= '0;
      sw_s1       <= '0;
      sw_s2       <= '0;
      ext_s1      <= 1'b0;
      ext_s2      <= 1'b0;
      irq_pending <= 1'b0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      // A CPU write to CTRL overrides the FSM's one-shot enable clear.
      if (wr_ctrl && PrBE[0]) ctrl <= PrWD[3:0];
      else if (en_clr)        ctrl <= {ctrl[3:1], 1'b0};
      if (wr_preset) preset <= merge_bytes(preset, PrWD, PrBE);
      if (wr_led)    led    <= merge_bytes(led, PrWD, PrBE);
      if (wr_ctrl || wr_preset) irq_pending <= 1'b0;
      else if (irq_set)         irq_pending <= 1'b1;
      sw_s1  <= sw_in;
      sw_s2  <= sw_s1;
      ext_s1 <= ext_irq;
      ext_s2 <= ext_s1;
    end
  end

  always_comb begin
    PrRD = '0;
    case (PrAddr)
      A_CTRL:   PrRD = {28'b0, ctrl};
      A_PRESET: PrRD = preset;
      A_COUNT:  PrRD = count;
      A_LED:    PrRD = led;
      A_SW:     PrRD = sw_s2;
      default:  PrRD = '0;
    endcase
  end

  assign HWInt   = {4'b0000, ext_s2,
                    reload ? (im && state == S_INT) : (irq_pending && im)};
  assign led_out = led;

endmodule

// File: tb/tb_io_bridge.sv
// Randomized and directed bench for io_bridge with a tick-based timer reference model and scoreboard.
module tb_io_bridge;

  localparam logic [31:0] CTRL_A = 32'h7F00, PRE_A = 32'h7F04, CNT_A = 32'h7F08;
  localparam logic [31:0] LED_A  = 32'h7F10, SW_A  = 32'h7F14;

  logic        clk, rst;
  logic [29:0] PrAddr;
  logic [31:0] PrWD, PrRD, sw_in, led_out;
  logic [3:0]  PrBE;
  logic        IOWrite, ext_irq;
  logic [5:0]  HWInt;

  io_bridge dut (
    .clk(clk), .rst(rst), .PrAddr(PrAddr), .PrWD(PrWD), .PrBE(PrBE),
    .IOWrite(IOWrite), .PrRD(PrRD), .HWInt(HWInt), .sw_in(sw_in),
    .led_out(led_out), .ext_irq(ext_irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0] rd;
    logic [5:0]  hw;
    logic [31:0] led;
  } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;

  // Timer modelled as "ticks since the period's load": tick 0 is the load cycle,
  // the interrupt cycle is tick max(P,1)+1, counts in between are P-(tick-1).
  logic [3:0]  m_ctrl;
  logic [31:0] m_preset, m_count, m_led, m_P, m_sw1, m_sw2;
  logic        m_irq, m_ex1, m_ex2, m_run;
  int          m_tick;

  function automatic int t_int();
    return (m_P <= 32'd1) ? 2 : int'(m_P) + 1;
  endfunction

  function automatic logic [31:0] cur_count();
    if (!m_run || m_tick == 0) return m_count;
    if (m_tick >= t_int())     return 32'd0;
    return m_P - 32'(m_tick - 1);
  endfunction

  function automatic logic [31:0] bytes_in(input logic [31:0] old, input logic [31:0] wd,
                                           input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  function automatic void model_reset();
    m_ctrl = '0; m_preset = '0; m_count = '0; m_led = '0; m_P = '0;
    m_sw1 = '0; m_sw2 = '0; m_irq = 1'b0; m_ex1 = 1'b0; m_ex2 = 1'b0;
    m_run = 1'b0; m_tick = 0;
  endfunction

  // Advance the model across one rising edge using the inputs held during the cycle.
  function automatic void model_step();
    logic [31:0] cc, ba;
    logic        clr_en;
    if (!rst) begin
      model_reset();
      return;
    end
    cc = cur_count();
    clr_en = 1'b0;
    if (!m_run) begin
      if (m_ctrl[0]) begin m_run = 1'b1; m_tick = 0; end
    end else if (m_tick == 0) begin
      m_P = m_preset; m_count = m_preset; m_tick = 1;
    end else if (m_tick < t_int()) begin
      if (!m_ctrl[0]) begin m_run = 1'b0; m_count = cc; end
      else m_tick++;
    end else if (m_ctrl[2:1] == 2'b01) begin
      m_tick = 0; m_count = '0;
    end else begin
      m_irq = 1'b1; clr_en = 1'b1; m_run = 1'b0; m_count = '0;
    end
    if (clr_en) m_ctrl[0] = 1'b0;
    ba = {PrAddr, 2'b00};
    if (IOWrite) begin
      if (ba == CTRL_A) begin
        m_irq = 1'b0;
        if (PrBE[0]) m_ctrl = PrWD[3:0];
      end else if (ba == PRE_A) begin
        m_irq = 1'b0;
        m_preset = bytes_in(m_preset, PrWD, PrBE);
      end else if (ba == LED_A) begin
        m_led = bytes_in(m_led, PrWD, PrBE);
      end
    end
    m_sw2 = m_sw1; m_sw1 = sw_in;
    m_ex2 = m_ex1; m_ex1 = ext_irq;
  endfunction

  function automatic void push_expect();
    exp_t e;
    logic [31:0] ba;
    logic        t2;
    ba = {PrAddr, 2'b00};
    if (ba == CTRL_A)     e.rd = {28'b0, m_ctrl};
    else if (ba == PRE_A) e.rd = m_preset;
    else if (ba == CNT_A) e.rd = cur_count();
    else if (ba == LED_A) e.rd = m_led;
    else if (ba == SW_A)  e.rd = m_sw2;
    else                  e.rd = 32'd0;
    if (m_ctrl[2:1] == 2'b01) t2 = m_ctrl[3] && m_run && (m_tick >= t_int());
    else                      t2 = m_irq && m_ctrl[3];
    e.hw  = {4'b0000, m_ex2, t2};
    e.led = m_led;
    exp_q.push_back(e);
  endfunction

  task automatic drive(input logic w, input logic [31:0] ba, input logic [31:0] wd,
                       input logic [3:0] be);
    @(posedge clk);
    model_step();
    #1;
    IOWrite = w; PrAddr = ba[31:2]; PrWD = wd; PrBE = be;
    push_expect();
  endtask

  task automatic rd_n(input int n, input logic [31:0] ba);
    for (int i = 0; i < n; i++) drive(1'b0, ba, 32'd0, 4'h0);
  endtask

  task automatic async_reset();
    @(posedge clk);
    model_step();
    #2;
    rst = 1'b0;
    model_reset();
    push_expect();
  endtask

  function automatic void cmp(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, got, want);
    end
  endfunction

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        cmp("prrd", PrRD, e.rd);
        cmp("hwint", {26'b0, HWInt}, {26'b0, e.hw});
        cmp("led_out", led_out, e.led);
      end
    end
  end

  logic [31:0] addrs [7];
  initial begin
    int          k;
    logic        w;
    logic [31:0] d;
    logic [3:0]  be;
    addrs = '{CTRL_A, PRE_A, CNT_A, LED_A, SW_A, 32'h0, 32'h7F18};
    rst = 1'b0; IOWrite = 1'b0; PrAddr = '0; PrWD = '0; PrBE = '0;
    sw_in = 32'hFFFF_FFFF; ext_irq = 1'b1;
    model_reset();

    // Read sweep while held in reset, then after release.
    for (int i = 0; i < 6; i++) drive(1'b0, addrs[i], 32'd0, 4'h0);
    rst = 1'b1; sw_in = '0; ext_irq = 1'b0;
    for (int i = 0; i < 6; i++) drive(1'b0, addrs[i], 32'd0, 4'h0);

    // Byte-enable merge and read-only COUNT.
    drive(1'b1, LED_A, 32'hAABBCCDD, 4'b1111);
    drive(1'b1, LED_A, 32'h11223344, 4'b0101);
    rd_n(2, LED_A);
    drive(1'b1, CNT_A, 32'hFFFF_FFFF, 4'hF);
    rd_n(2, CNT_A);

    // One-shot.
    drive(1'b1, PRE_A, 32'd5, 4'hF);
    drive(1'b1, CTRL_A, 32'h9, 4'hF);
    for (int i = 0; i < 12; i++) drive(1'b0, (i % 2) ? CTRL_A : CNT_A, 32'd0, 4'h0);
    drive(1'b1, CTRL_A, 32'h0, 4'hF);
    rd_n(3, CTRL_A);

    // Auto-reload with and without interrupt mask.
    drive(1'b1, PRE_A, 32'd3, 4'hF);
    drive(1'b1, CTRL_A, 32'hB, 4'hF);
    rd_n(22, CNT_A);
    drive(1'b1, CTRL_A, 32'h3, 4'hF);
    rd_n(12, CNT_A);
    drive(1'b1, CTRL_A, 32'h0, 4'hF);
    rd_n(3, CNT_A);

    // Disable mid-count, then re-enable.
    drive(1'b1, PRE_A, 32'd100, 4'hF);
    drive(1'b1, CTRL_A, 32'h9, 4'hF);
    rd_n(20, CNT_A);
    drive(1'b1, CTRL_A, 32'h0, 4'hF);
    rd_n(10, CNT_A);
    drive(1'b1, CTRL_A, 32'h9, 4'hF);
    rd_n(10, CNT_A);
    drive(1'b1, CTRL_A, 32'h0, 4'hF);

    // Synchronizers.
    sw_in = 32'h5A5A0F0F; ext_irq = 1'b1;
    rd_n(5, SW_A);
    ext_irq = 1'b0;
    rd_n(4, SW_A);

    // Asynchronous reset during counting.
    drive(1'b1, LED_A, 32'hDEADBEEF, 4'hF);
    drive(1'b1, PRE_A, 32'd50, 4'hF);
    drive(1'b1, CTRL_A, 32'h9, 4'hF);
    ext_irq = 1'b1;
    rd_n(10, CNT_A);
    async_reset();
    rd_n(2, LED_A);
    rst = 1'b1;
    rd_n(3, CNT_A);

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      k  = $urandom_range(0, 6);
      w  = ($urandom_range(0, 9) < 3);
      d  = $urandom;
      be = 4'($urandom);
      if (addrs[k] == PRE_A) d = $urandom_range(0, 9);
      if ($urandom_range(0, 7) == 0) sw_in = $urandom;
      if ($urandom_range(0, 5) == 0) ext_irq = ~ext_irq;
      drive(w, addrs[k], d, be);
    end

    @(negedge clk);
    #1;
    cmp("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
